// File: rtl/vmicro16_apb_rr_intercon.sv
// Round-robin multi-master APB interconnect: one master at a time is granted the
// shared slave bus, with address-decoded slave select and a PREADY timeout watchdog.
module vmicro16_apb_rr_intercon #(
  parameter int MASTER_PORTS   = 4,
  parameter int SLAVE_PORTS    = 6,
  parameter int BUS_WIDTH      = 16,
  parameter int DEC_LSB        = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int GNT_W = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [MASTER_PORTS-1:0]           S_PSLVERR,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]            M_PREADY,
  output logic [GNT_W-1:0]                  grant
);

  localparam int SEL_W = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                   state_q, state_d;
  logic [GNT_W-1:0]         grant_q, grant_d;
  logic [SEL_W-1:0]         idx_q, idx_d;
  logic [BUS_WIDTH-1:0]     paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [BUS_WIDTH-1:0]     pwdata_q, pwdata_d;
  logic [SLAVE_PORTS-1:0]   psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic [BUS_WIDTH-1:0]     prdata_q, prdata_d;
  logic [MASTER_PORTS-1:0]  pready_q, pready_d;
  logic [MASTER_PORTS-1:0]  pslverr_q, pslverr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     req_found;
  logic [GNT_W-1:0]         req_idx;
  logic [GNT_W-1:0]         cand;
  logic [BUS_WIDTH-1:0]     req_addr;
  logic [SEL_W-1:0]         req_sel;
  logic                     slv_ready;
  logic [BUS_WIDTH-1:0]     slv_rdata;
  logic                     unused_penable;

  // PENABLE from the masters carries no information the arbiter needs.
  assign unused_penable = ^S_PENABLE;

  // Round-robin search starting just after the last granted master.
  always_comb begin
    req_found = 1'b0;
    req_idx   = grant_q;
    cand      = grant_q;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      cand = GNT_W'((int'(grant_q) + k) % MASTER_PORTS);
      if (!req_found && S_PSELx[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
    req_addr = S_PADDR[int'(req_idx)*BUS_WIDTH +: BUS_WIDTH];
    req_sel  = req_addr[DEC_LSB +: SEL_W];
  end

  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      if (int'(idx_q) == s) begin
        slv_ready = M_PREADY[s];
        slv_rdata = M_PRDATA[s*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    prdata_d  = prdata_q;
    pready_d  = '0;
    pslverr_d = '0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d  = req_idx;
          paddr_d  = req_addr;
          pwrite_d = S_PWRITE[req_idx];
          pwdata_d = S_PWDATA[int'(req_idx)*BUS_WIDTH +: BUS_WIDTH];
          idx_d    = req_sel;
          // An undecoded index leaves every select low, so it never reaches a slave.
          for (int s = 0; s < SLAVE_PORTS; s++) begin
            psel_d[s] = (int'(req_sel) == s);
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (psel_q != '0) begin
          penable_d = 1'b1;
          cnt_d     = '0;
          state_d   = ACCESS;
        end else begin
          prdata_d           = '0;
          pready_d[grant_q]  = 1'b1;
          pslverr_d[grant_q] = 1'b1;
          state_d            = RESP;
        end
      end
      ACCESS: begin
        if (slv_ready) begin
          prdata_d          = slv_rdata;
          pready_d[grant_q] = 1'b1;
          psel_d            = '0;
          penable_d         = 1'b0;
          state_d           = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          prdata_d           = '0;
          pready_d[grant_q]  = 1'b1;
          pslverr_d[grant_q] = 1'b1;
          psel_d             = '0;
          penable_d          = 1'b0;
          state_d            = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= GNT_W'(MASTER_PORTS - 1);
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= '0;
      pslverr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign M_PADDR   = paddr_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PWDATA  = pwdata_q;
  assign M_PSELx   = psel_q;
  assign M_PENABLE = penable_q;
  assign S_PREADY  = pready_q;
  assign S_PSLVERR = pslverr_q;
  assign grant     = grant_q;

  for (genvar gi = 0; gi < MASTER_PORTS; gi++) begin : g_rdata
    assign S_PRDATA[gi*BUS_WIDTH +: BUS_WIDTH] = prdata_q;
  end

endmodule

// File: tb/tb_vmicro16_apb_rr_intercon.sv
// Bench for the round-robin APB interconnect: behavioural slaves with programmable
// wait states, a response scoreboard, a vector table and hand-written corner sequences.
module tb_vmicro16_apb_rr_intercon;

  localparam int MP = 4;
  localparam int SP = 6;
  localparam int BW = 16;

  logic              clk;
  logic              reset;
  logic [MP*BW-1:0]  S_PADDR;
  logic [MP-1:0]     S_PWRITE;
  logic [MP-1:0]     S_PSELx;
  logic [MP-1:0]     S_PENABLE;
  logic [MP*BW-1:0]  S_PWDATA;
  logic [MP*BW-1:0]  S_PRDATA;
  logic [MP-1:0]     S_PREADY;
  logic [MP-1:0]     S_PSLVERR;
  logic [BW-1:0]     M_PADDR;
  logic              M_PWRITE;
  logic [SP-1:0]     M_PSELx;
  logic              M_PENABLE;
  logic [BW-1:0]     M_PWDATA;
  logic [SP*BW-1:0]  M_PRDATA;
  logic [SP-1:0]     M_PREADY;
  logic [1:0]        grant;

  vmicro16_apb_rr_intercon #(
    .MASTER_PORTS(MP), .SLAVE_PORTS(SP), .BUS_WIDTH(BW), .DEC_LSB(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .grant(grant)
  );

  typedef struct {
    int          master;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    int          slave_wait;
    logic [15:0] slave_data;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          master;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } sb_t;

  sb_t         sb[$];
  vec_t        vecs [9];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          slv_wait [SP];
  logic [15:0] slv_data [SP];
  int          acc_cnt = 0;
  int          wr_count = 0;
  logic [15:0] last_wr = '0;
  logic [15:0] last_rdata = '0;
  logic [MP-1:0] persist = '0;
  logic        cur_active = 1'b0;
  int          cur_issue = 0;
  logic [15:0] cur_addr = '0;
  logic [15:0] cur_wdata = '0;
  logic        cur_wr = 1'b0;
  logic [SP-1:0] cur_psel = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe DUT outputs at the falling edge, then update the slave model.
  task automatic step();
    sb_t e;
    int  m;
    @(negedge clk);
    if (S_PREADY != '0) begin
      chk("pready_onehot", $countones(S_PREADY), 1);
      m = 0;
      for (int i = 0; i < MP; i++) if (S_PREADY[i]) m = i;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pready: got master %0d expected none (cycle %0d)", m, cyc);
      end else begin
        e = sb.pop_front();
        chk("master", m, e.master);
        chk("pslverr", S_PSLVERR[m], e.err);
        for (int i = 0; i < MP; i++) chk("prdata", S_PRDATA[i*BW +: BW], e.rdata);
        if (e.cyc >= 0) chk("latency", cyc, e.cyc);
        last_rdata = e.rdata;
        $display("txn master=%0d rdata=%h err=%b cycle=%0d", m, S_PRDATA[m*BW +: BW], S_PSLVERR[m], cyc);
      end
      for (int i = 0; i < MP; i++) if (S_PREADY[i] && !persist[i]) S_PSELx[i] = 1'b0;
    end else begin
      chk("pslverr_idle", S_PSLVERR, 0);
      chk("prdata_hold", S_PRDATA[BW-1:0], last_rdata);
    end
    chk("psel_onehot", ($countones(M_PSELx) <= 1), 1);
    if (cur_active) begin
      if (M_PSELx != '0) begin
        chk("paddr_stable", M_PADDR, cur_addr);
        chk("pwdata_stable", M_PWDATA, cur_wdata);
        chk("pwrite_stable", M_PWRITE, cur_wr);
        chk("psel_slave", M_PSELx, cur_psel);
      end
      if (cyc == cur_issue + 1) begin
        chk("setup_psel", M_PSELx, cur_psel);
        chk("setup_penable", M_PENABLE, 0);
      end
      if (cyc == cur_issue + 2 && cur_psel != '0) chk("access_penable", M_PENABLE, 1);
    end
    M_PREADY = '0;
    if (M_PENABLE && M_PSELx != '0) begin
      for (int s = 0; s < SP; s++) begin
        if (M_PSELx[s] && acc_cnt == slv_wait[s]) begin
          M_PREADY[s] = 1'b1;
          if (M_PWRITE) begin
            wr_count++;
            last_wr = M_PWDATA;
          end
        end
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
    for (int s = 0; s < SP; s++) M_PRDATA[s*BW +: BW] = slv_data[s];
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL response_timeout: got %0d responses outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int  s;
    int  wr_before;
    sb_t e;
    s = int'(v.addr[10:8]);
    if (s < SP) begin
      slv_wait[s] = v.slave_wait;
      slv_data[s] = v.slave_data;
    end
    S_PADDR[v.master*BW +: BW]  = v.addr;
    S_PWDATA[v.master*BW +: BW] = v.wdata;
    S_PWRITE[v.master]          = v.wr;
    S_PSELx[v.master]           = 1'b1;
    cur_active = 1'b1;
    cur_issue  = cyc;
    cur_addr   = v.addr;
    cur_wdata  = v.wdata;
    cur_wr     = v.wr;
    cur_psel   = (s < SP) ? (SP'(1) << s) : '0;
    wr_before  = wr_count;
    e = '{v.master, v.exp_rdata, v.exp_err, cyc + v.exp_lat};
    sb.push_back(e);
    step();
    // The master changes its bus after the grant; the latched transfer must not follow.
    S_PADDR[v.master*BW +: BW]  = ~v.addr;
    S_PWDATA[v.master*BW +: BW] = ~v.wdata;
    S_PWRITE[v.master]          = ~v.wr;
    wait_done(200);
    step();
    chk("write_count", wr_count - wr_before, (v.wr && !v.exp_err) ? 1 : 0);
    if (v.wr && !v.exp_err) chk("write_data", last_wr, v.wdata);
    chk("grant", grant, v.master);
    cur_active = 1'b0;
  endtask

  initial begin
    sb_t e;
    int  n0;
    vecs[0] = '{2, 16'h0304, 1'b0, 16'h0000, 0,    16'hBEEF, 16'hBEEF, 1'b0, 3};
    vecs[1] = '{1, 16'h0110, 1'b1, 16'h1234, 5,    16'h5555, 16'h5555, 1'b0, 8};
    vecs[2] = '{0, 16'h0700, 1'b0, 16'h0000, 0,    16'h0000, 16'h0000, 1'b1, 2};
    vecs[3] = '{3, 16'h0000, 1'b0, 16'h0000, 2,    16'hA5A5, 16'hA5A5, 1'b0, 5};
    vecs[4] = '{0, 16'h05FF, 1'b0, 16'h0000, 0,    16'h1357, 16'h1357, 1'b0, 3};
    vecs[5] = '{1, 16'h0600, 1'b1, 16'hDEAD, 0,    16'h0000, 16'h0000, 1'b1, 2};
    vecs[6] = '{2, 16'h02AB, 1'b1, 16'hC0DE, 1,    16'h0F0F, 16'h0F0F, 1'b0, 4};
    vecs[7] = '{3, 16'h0400, 1'b0, 16'h0000, 1000, 16'h7777, 16'h0000, 1'b1, 66};
    vecs[8] = '{0, 16'h0000, 1'b0, 16'h0000, 0,    16'h2468, 16'h2468, 1'b0, 3};

    for (int s = 0; s < SP; s++) begin
      slv_wait[s] = 0;
      slv_data[s] = '0;
    end
    reset     = 1'b1;
    S_PADDR   = '0;
    S_PWRITE  = '0;
    S_PSELx   = '0;
    S_PENABLE = '0;
    S_PWDATA  = '0;
    M_PRDATA  = '0;
    M_PREADY  = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_psel", M_PSELx, 0);
    chk("rst_penable", M_PENABLE, 0);
    chk("rst_paddr", M_PADDR, 0);
    chk("rst_pwdata", M_PWDATA, 0);
    chk("rst_pwrite", M_PWRITE, 0);
    chk("rst_pready", S_PREADY, 0);
    chk("rst_prdata", S_PRDATA, 0);
    chk("rst_grant", grant, 3);

    // Masters 0, 1 and 3 keep requesting: grants must rotate 0,1,3 every 4 cycles.
    S_PADDR[0*BW +: BW] = 16'h0000;
    S_PADDR[1*BW +: BW] = 16'h0100;
    S_PADDR[3*BW +: BW] = 16'h0300;
    slv_data[0] = 16'h1000;
    slv_data[1] = 16'h1001;
    slv_data[3] = 16'h1003;
    persist = 4'b1011;
    S_PSELx = 4'b1011;
    n0 = cyc;
    for (int k = 0; k < 6; k++) begin
      e.master = (k % 3 == 2) ? 3 : (k % 3);
      e.rdata  = slv_data[e.master];
      e.err    = 1'b0;
      e.cyc    = n0 + 3 + 4 * k;
      sb.push_back(e);
    end
    wait_done(100);
    S_PSELx = '0;
    persist = '0;
    repeat (3) step();

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Reset in the middle of a wait-stated access aborts it without a response.
    slv_wait[1] = 10;
    slv_data[1] = 16'h6A6A;
    S_PADDR[1*BW +: BW]  = 16'h0110;
    S_PWDATA[1*BW +: BW] = 16'h0000;
    S_PWRITE[1] = 1'b0;
    S_PSELx[1]  = 1'b1;
    cur_active = 1'b1;
    cur_issue  = cyc;
    cur_addr   = 16'h0110;
    cur_wdata  = 16'h0000;
    cur_wr     = 1'b0;
    cur_psel   = 6'b000010;
    repeat (4) step();
    chk("pre_rst_penable", M_PENABLE, 1);
    reset = 1'b1;
    last_rdata = '0;
    step();
    chk("midrst_psel", M_PSELx, 0);
    chk("midrst_penable", M_PENABLE, 0);
    chk("midrst_pready", S_PREADY, 0);
    chk("midrst_grant", grant, 3);
    reset = 1'b0;
    cur_issue = cyc;
    e = '{1, 16'h6A6A, 1'b0, cyc + 13};
    sb.push_back(e);
    wait_done(100);
    step();
    chk("post_rst_grant", grant, 1);
    cur_active = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
